// File: rtl/lif_pkg.sv
// Shared definitions for the time-multiplexed LIF neuron scheduler.
//
// Contents:
//   STATE_W       - membrane state width
//   CUR_W         - input current width
//   SUM_W         - width of current + (state >> 1), wide enough not to wrap
//   DEF_THRESHOLD - default firing threshold
//   lif_fsm_e     - sweep controller states
package lif_pkg;

    localparam int STATE_W       = 5;
    localparam int CUR_W         = 5;
    localparam int SUM_W         = 6;
    localparam int DEF_THRESHOLD = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } lif_fsm_e;

endpackage

// File: rtl/lif_step.sv
// Combinational single-neuron leaky integrate-and-fire update.
//
// Ports:
//   cur_i    in  CUR_W    input current of the neuron being updated
//   state_i  in  STATE_W  current membrane state
//   thresh_i in  STATE_W  firing threshold
//   state_o  out STATE_W  next membrane state (0 on fire, else saturated sum)
//   fire_o   out 1        neuron fires this update
module lif_step
    import lif_pkg::*;
(
    input  logic [CUR_W-1:0]   cur_i,
    input  logic [STATE_W-1:0] state_i,
    input  logic [STATE_W-1:0] thresh_i,
    output logic [STATE_W-1:0] state_o,
    output logic               fire_o
);

    // Clamp the 6-bit sum into the 5-bit state range.
    function automatic logic [STATE_W-1:0] sat_state(input logic [SUM_W-1:0] s);
        if (s > SUM_W'((1 << STATE_W) - 1)) begin
            return '1;
        end else begin
            return s[STATE_W-1:0];
        end
    endfunction

    logic [SUM_W-1:0] sum;

    always_comb begin
        // Leak is a halving of the previous state.
        sum     = SUM_W'(cur_i) + SUM_W'(state_i >> 1);
        fire_o  = (sum >= SUM_W'(thresh_i));
        state_o = fire_o ? '0 : sat_state(sum);
    end

endmodule

// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF neuron array: NUM_NEURONS neurons share one lif_step
// datapath; a step pulse sweeps every neuron once, in index order.
//
// Parameters:
//   NUM_NEURONS  - neuron count (power of two, 2..32)
//   THRESHOLD    - firing threshold (1..31)
//   REFRAC_STEPS - refractory sweeps after a fire (1..7)
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   wr_en       in   current register write strobe
//   wr_addr     in   neuron index to write
//   wr_data     in   new input current
//   step        in   request one timestep sweep (ignored while busy)
//   busy        out  sweep or done cycle in progress
//   done        out  one-cycle pulse at sweep completion
//   spike_valid out  one cycle per fired neuron, the cycle after its update
//   spike_idx   out  index of the fired neuron
//   spike_vec   out  spike bitmap of the last completed timestep
//   mon_addr    in   monitor select
//   mon_state   out  membrane state of the selected neuron (combinational)
//
// Build option: define LIF_REFRACTORY_EN to add a per-neuron refractory
// counter that holds a neuron at 0 for REFRAC_STEPS sweeps after it fires.
module lif_scheduler
    import lif_pkg::*;
#(
    parameter int NUM_NEURONS  = 8,
    parameter int THRESHOLD    = DEF_THRESHOLD,
    parameter int REFRAC_STEPS = 2,
    localparam int IDX_W       = $clog2(NUM_NEURONS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_addr,
    input  logic [CUR_W-1:0]       wr_data,
    input  logic                   step,
    output logic                   busy,
    output logic                   done,
    output logic                   spike_valid,
    output logic [IDX_W-1:0]       spike_idx,
    output logic [NUM_NEURONS-1:0] spike_vec,
    input  logic [IDX_W-1:0]       mon_addr,
    output logic [STATE_W-1:0]     mon_state
);

    localparam logic [2:0] REFRAC_INIT = 3'(REFRAC_STEPS);

    lif_fsm_e               state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_NEURONS-1:0] pend_q, pend_d;
    logic [NUM_NEURONS-1:0] spike_vec_q;
    logic                   spike_valid_q;
    logic [IDX_W-1:0]       spike_idx_q;
    logic                   busy_q;
    logic [CUR_W-1:0]       cur_q [NUM_NEURONS];
    logic [STATE_W-1:0]     mem_q [NUM_NEURONS];

    logic [STATE_W-1:0]     step_state, upd_state;
    logic                   step_fire, upd_fire;
    logic                   sweep_act, last_idx;

    assign sweep_act = (state_q == ST_SWEEP);
    assign last_idx  = (idx_q == IDX_W'(NUM_NEURONS - 1));

    lif_step u_step (
        .cur_i    (cur_q[idx_q]),
        .state_i  (mem_q[idx_q]),
        .thresh_i (STATE_W'(THRESHOLD)),
        .state_o  (step_state),
        .fire_o   (step_fire)
    );

`ifdef LIF_REFRACTORY_EN
    logic [2:0] refr_q [NUM_NEURONS];
    logic       in_refrac;

    // A refractory neuron is pinned at 0 and cannot fire; its counter
    // counts down once per sweep.
    assign in_refrac = (refr_q[idx_q] != 3'd0);
    assign upd_state = in_refrac ? '0 : step_state;
    assign upd_fire  = step_fire & ~in_refrac;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                refr_q[n] <= '0;
            end
        end else if (sweep_act) begin
            if (in_refrac) begin
                refr_q[idx_q] <= refr_q[idx_q] - 3'd1;
            end else if (upd_fire) begin
                refr_q[idx_q] <= REFRAC_INIT;
            end
        end
    end
`else
    logic unused_refrac;
    assign unused_refrac = ^REFRAC_INIT;
    assign upd_state     = step_state;
    assign upd_fire      = step_fire;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                end
            end
            ST_SWEEP: begin
                // Neuron 0's update starts a fresh bitmap for this timestep.
                pend_d = ((idx_q == '0) ? '0 : pend_q)
                       | (upd_fire ? (NUM_NEURONS'(1) << idx_q) : '0);
                if (last_idx) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pend_q        <= '0;
            spike_vec_q   <= '0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            busy_q        <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                cur_q[n] <= '0;
                mem_q[n] <= '0;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pend_q        <= pend_d;
            // Registered so busy rises one edge after step is accepted and
            // stays up through the done cycle.
            busy_q        <= sweep_act;
            // The last neuron's spike lands in the done cycle.
            spike_valid_q <= sweep_act & upd_fire;
            if (sweep_act && upd_fire) begin
                spike_idx_q <= idx_q;
            end
            if (sweep_act && last_idx) begin
                spike_vec_q <= pend_d;
            end
            if (sweep_act) begin
                mem_q[idx_q] <= upd_state;
            end
            // Nonblocking: a same-edge write does not affect this update.
            if (wr_en) begin
                cur_q[wr_addr] <= wr_data;
            end
        end
    end

    assign busy        = busy_q;
    assign done        = (state_q == ST_DONE);
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign spike_vec   = spike_vec_q;
    assign mon_state   = mem_q[mon_addr];

endmodule

// File: tb/tb_lif_scheduler.sv
module tb_lif_scheduler;

    localparam int N      = 8;
    localparam int THR_A  = 10;
    localparam int REFR_A = 2;
`ifdef LIF_REFRACTORY_EN
    localparam bit REFR_ON = 1'b1;
`else
    localparam bit REFR_ON = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       wr_en, wr_en_b;
    logic [2:0] wr_addr, wr_addr_b;
    logic [4:0] wr_data, wr_data_b;
    logic       step, step_b;
    logic [2:0] mon_addr, mon_addr_b;
    logic       busy, done, spike_valid;
    logic [2:0] spike_idx;
    logic [7:0] spike_vec;
    logic [4:0] mon_state;
    logic       busy_b, done_b, spike_valid_b;
    logic [2:0] spike_idx_b;
    logic [7:0] spike_vec_b;
    logic [4:0] mon_state_b;

    int n_run  = 0;
    int n_fail = 0;
    int n_done = 0;
    bit chk_en = 0;

    lif_scheduler #(.NUM_NEURONS(N), .THRESHOLD(THR_A), .REFRAC_STEPS(REFR_A)) dut_a (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .step(step), .busy(busy), .done(done), .spike_valid(spike_valid),
        .spike_idx(spike_idx), .spike_vec(spike_vec), .mon_addr(mon_addr), .mon_state(mon_state)
    );

    lif_scheduler #(.NUM_NEURONS(N), .THRESHOLD(31), .REFRAC_STEPS(2)) dut_b (
        .clk(clk), .reset(reset), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .step(step_b), .busy(busy_b), .done(done_b), .spike_valid(spike_valid_b),
        .spike_idx(spike_idx_b), .spike_vec(spike_vec_b), .mon_addr(mon_addr_b), .mon_state(mon_state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model of dut_a ----------------
    // phase 0 = idle, 1..N = neuron (phase-1) is next to update, N+1 = done cycle
    int         m_phase = 0;
    int         m_cur [N];
    int         m_st  [N];
    int         m_rf  [N];
    logic [7:0] m_pend = '0;
    logic [7:0] m_vec  = '0;
    bit         m_busy = 0, m_done = 0, m_sv = 0;
    int         m_si   = 0;
    int         mp_prev, mi, msum;

    initial begin
        for (int k = 0; k < N; k++) begin
            m_cur[k] = 0; m_st[k] = 0; m_rf[k] = 0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_pend = '0; m_vec = '0;
            m_busy = 0; m_done = 0; m_sv = 0; m_si = 0;
            for (int k = 0; k < N; k++) begin
                m_cur[k] = 0; m_st[k] = 0; m_rf[k] = 0;
            end
        end else begin
            mp_prev = m_phase;
            m_sv    = 0;
            if (mp_prev == 0) begin
                if (step) m_phase = 1;
            end else if (mp_prev <= N) begin
                mi = mp_prev - 1;
                if (mi == 0) m_pend = '0;
                if (REFR_ON && m_rf[mi] > 0) begin
                    m_st[mi] = 0;
                    m_rf[mi] = m_rf[mi] - 1;
                end else begin
                    msum = m_cur[mi] + m_st[mi] / 2;
                    if (msum >= THR_A) begin
                        m_st[mi]   = 0;
                        m_pend[mi] = 1'b1;
                        m_sv       = 1;
                        m_si       = mi;
                        m_rf[mi]   = REFR_A;
                    end else begin
                        m_st[mi] = (msum > 31) ? 31 : msum;
                    end
                end
                if (mi == N - 1) begin
                    m_vec   = m_pend;
                    m_phase = N + 1;
                end else begin
                    m_phase = mp_prev + 1;
                end
            end else begin
                m_phase = 0;
            end
            m_busy = (mp_prev >= 1) && (mp_prev <= N);
            m_done = (m_phase == N + 1);
            if (wr_en) m_cur[wr_addr] = int'(wr_data);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("spike_valid", spike_valid, m_sv);
            if (m_sv) chk("spike_idx", spike_idx, m_si);
            chk("spike_vec", spike_vec, m_vec);
            chk("mon_state", mon_state, m_st[mon_addr]);
        end
        if (done === 1'b1) n_done++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input int d);
        wr_en = 1'b1; wr_addr = 3'(a); wr_data = 5'(d);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr_b(input int a, input int d);
        wr_en_b = 1'b1; wr_addr_b = 3'(a); wr_data_b = 5'(d);
        tick();
        wr_en_b = 1'b0;
    endtask

    // Waits for done (bounded), then leaves the done cycle.
    task automatic wait_done(input bit on_b);
        int k;
        k = 0;
        while (((on_b ? done_b : done) !== 1'b1) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk(on_b ? "done_wait_b" : "done_wait", (k < 40), 1);
        tick();
    endtask

    task automatic run_step();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(1'b0);
    endtask

    task automatic run_step_b();
        step_b = 1'b1;
        tick();
        step_b = 1'b0;
        wait_done(1'b1);
    endtask

    logic [7:0] exp_vec5 [4];
    int         done_snap;

    initial begin
`ifdef LIF_REFRACTORY_EN
        exp_vec5[0] = 8'h02; exp_vec5[1] = 8'h00; exp_vec5[2] = 8'h00; exp_vec5[3] = 8'h02;
`else
        exp_vec5[0] = 8'h02; exp_vec5[1] = 8'h02; exp_vec5[2] = 8'h02; exp_vec5[3] = 8'h02;
`endif
        reset = 1'b1;
        wr_en = 0; wr_addr = 0; wr_data = 0; step = 0; mon_addr = 0;
        wr_en_b = 0; wr_addr_b = 0; wr_data_b = 0; step_b = 0; mon_addr_b = 3'd5;
        tick(); tick();
        chk_en = 1'b1;
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_spike_idx", spike_idx, 0);
        chk("rst_spike_vec", spike_vec, 0);
        chk("rst_mon_state", mon_state, 0);

        // Neuron 0 with current 12 fires on the first sweep
        wr(0, 12);
        mon_addr = 3'd0;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("fire0_spike_valid", spike_valid, 1);
        chk("fire0_spike_idx", spike_idx, 0);
        chk("fire0_mon", mon_state, 0);
        chk("fire0_busy", busy, 1);
        wait_done(1'b0);
        chk("fire0_vec", spike_vec, 8'h01);

        // Neuron 3 integrates 6, 9, then fires at sum 10
        wr(0, 0);
        wr(3, 6);
        mon_addr = 3'd3;
        run_step();
        chk("int3_s1", mon_state, 6);
        chk("int3_v1", spike_vec, 8'h00);
        run_step();
        chk("int3_s2", mon_state, 9);
        run_step();
        chk("int3_s3", mon_state, 0);
        chk("int3_v3", spike_vec, 8'h08);

        // A step arriving mid-sweep is dropped
        done_snap = n_done;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_done(1'b0);
        repeat (12) tick();
        chk("ignored_step_dones", n_done - done_snap, 1);
        chk("ignored_step_busy", busy, 0);

        // Write to neuron 2 on its own update edge: update sees the old current
        wr(3, 0);
        wr(2, 0);
        mon_addr = 3'd2;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'd15;
        tick();
        wr_en = 1'b0;
        wait_done(1'b0);
        chk("sameedge_s", mon_state, 0);
        chk("sameedge_v1", spike_vec, 8'h00);
        run_step();
        chk("sameedge_v2", spike_vec, 8'h04);

        // Neuron 1 driven hard for four sweeps (refractory-sensitive)
        wr(2, 0);
        wr(1, 15);
        mon_addr = 3'd1;
        for (int s = 0; s < 4; s++) begin
            run_step();
            chk("refr_vec", spike_vec, exp_vec5[s]);
            chk("refr_mon", mon_state, 0);
        end

        // Reset held two cycles in the middle of a sweep
        step = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_vec", spike_vec, 0);
        for (int a = 0; a < N; a++) begin
            mon_addr = 3'(a);
            #1;
            chk("midrst_mon", mon_state, 0);
        end
        // Currents were cleared too: a fresh sweep produces no spikes
        run_step();
        chk("postrst_vec", spike_vec, 8'h00);

        // THRESHOLD=31 instance: 20, 30, then sum 35 fires without wrapping
        wr_b(5, 20);
        run_step_b();
        chk("thr31_s1", mon_state_b, 20);
        chk("thr31_v1", spike_vec_b, 8'h00);
        run_step_b();
        chk("thr31_s2", mon_state_b, 30);
        run_step_b();
        chk("thr31_s3", mon_state_b, 0);
        chk("thr31_v3", spike_vec_b, 8'h20);

        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
